// File: rtl/write_back.sv
// Write-back stage: 2-entry result FIFO drained into the register file through an
// ISSUE/CONFIRM handshake, with youngest-writer forwarding to decode.
package wb_pkg;
   localparam logic [1:0] RF_NOP      = 2'd0;
   localparam logic [1:0] RF_WRITE    = 2'd1;
   localparam logic [1:0] RF_FINISHED = 2'd2;
endpackage

module write_back
   import wb_pkg::*;
#(
   parameter int LEN = 32
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           rdy_in,
   input  logic           in_valid,
   input  logic [4:0]     in_rd,
   input  logic [LEN-1:0] in_data,
   input  logic           in_wb_en,
   output logic           in_ready,
   output logic [1:0]     rf_signal,
   output logic [4:0]     rf_rd,
   output logic [LEN-1:0] rf_data,
   output logic           write_back_enabled,
   input  logic [1:0]     rf_status,
   output logic           fwd_valid,
   output logic [4:0]     fwd_rd,
   output logic [LEN-1:0] fwd_data,
   output logic [31:0]    retire_count
);

   typedef enum logic [1:0] {IDLE, ISSUE, CONFIRM} state_t;

   state_t         state, state_nxt;
   logic [4:0]     q_rd   [2];
   logic [LEN-1:0] q_data [2];
   logic           q_wb   [2];
   logic           wr_ptr, rd_ptr;
   logic [1:0]     count;
   logic           push, pop, tail;

   // rst is folded in so the MEM stage sees no ready while the FIFO is cleared
   assign in_ready = rdy_in && !rst && (count < 2'd2);
   assign push     = in_valid && in_ready;
   assign pop      = rdy_in && (state == CONFIRM) && (rf_status == RF_FINISHED);
   assign tail     = ~wr_ptr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         wr_ptr       <= 1'b0;
         rd_ptr       <= 1'b0;
         count        <= 2'd0;
         retire_count <= 32'd0;
         for (int i = 0; i < 2; i++) begin
            q_rd[i]   <= 5'd0;
            q_data[i] <= '0;
            q_wb[i]   <= 1'b0;
         end
      end else begin
         state <= state_nxt;
         if (push) begin
            q_rd[wr_ptr]   <= in_rd;
            q_data[wr_ptr] <= in_data;
            q_wb[wr_ptr]   <= in_wb_en;
            wr_ptr         <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr       <= ~rd_ptr;
            retire_count <= retire_count + 32'd1;
         end
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // An entry arriving on the same edge counts as present, so issue follows acceptance directly
   always_comb begin
      state_nxt = state;
      if (rdy_in) begin
         case (state)
            IDLE:    if (count != 2'd0 || push) state_nxt = ISSUE;
            ISSUE:   state_nxt = CONFIRM;
            CONFIRM: if (pop) state_nxt = (count > 2'd1 || push) ? ISSUE : IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      write_back_enabled = 1'b0;
      rf_signal          = RF_NOP;
      rf_rd              = 5'd0;
      rf_data            = '0;
      if (state == ISSUE) begin
         write_back_enabled = 1'b1;
         rf_rd              = q_rd[rd_ptr];
         rf_data            = q_data[rd_ptr];
         if (q_wb[rd_ptr] && q_rd[rd_ptr] != 5'd0) rf_signal = RF_WRITE;
      end
   end

   // Tail is the youngest entry; fall back to the head only when both slots are live
   always_comb begin
      fwd_valid = 1'b0;
      fwd_rd    = 5'd0;
      fwd_data  = '0;
      if (count != 2'd0 && q_wb[tail] && q_rd[tail] != 5'd0) begin
         fwd_valid = 1'b1;
         fwd_rd    = q_rd[tail];
         fwd_data  = q_data[tail];
      end else if (count == 2'd2 && q_wb[rd_ptr] && q_rd[rd_ptr] != 5'd0) begin
         fwd_valid = 1'b1;
         fwd_rd    = q_rd[rd_ptr];
         fwd_data  = q_data[rd_ptr];
      end
   end

endmodule

// File: tb/tb_write_back.sv
// Directed bench for write_back: single write, x0 suppression, back-pressure,
// forwarding, freeze and async reset, checked against hand-computed values.
module tb_write_back;
   import wb_pkg::*;

   logic        clk = 1'b0;
   logic        rst, rdy_in, in_valid, in_wb_en, in_ready;
   logic [4:0]  in_rd, rf_rd, fwd_rd;
   logic [31:0] in_data, rf_data, fwd_data, retire_count;
   logic [1:0]  rf_signal, rf_status;
   logic        write_back_enabled, fwd_valid;

   int total = 0;
   int bad   = 0;

   write_back #(.LEN(32)) dut (
      .clk(clk), .rst(rst), .rdy_in(rdy_in),
      .in_valid(in_valid), .in_rd(in_rd), .in_data(in_data), .in_wb_en(in_wb_en),
      .in_ready(in_ready),
      .rf_signal(rf_signal), .rf_rd(rf_rd), .rf_data(rf_data),
      .write_back_enabled(write_back_enabled), .rf_status(rf_status),
      .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
      .retire_count(retire_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // advance past the next rising edge; checks then see post-edge state
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [4:0] rd, input logic [31:0] d, input logic wb);
      in_valid = v;
      in_rd    = rd;
      in_data  = d;
      in_wb_en = wb;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_we"},  write_back_enabled, 1'b0);
      chk({tag, "_sig"}, rf_signal, RF_NOP);
      chk({tag, "_rd"},  rf_rd, 5'd0);
      chk({tag, "_dat"}, rf_data, 32'd0);
   endtask

   task automatic chk_issue(input string tag, input logic [1:0] sig, input logic [4:0] rd,
                            input logic [31:0] d);
      chk({tag, "_we"},  write_back_enabled, 1'b1);
      chk({tag, "_sig"}, rf_signal, sig);
      chk({tag, "_rd"},  rf_rd, rd);
      chk({tag, "_dat"}, rf_data, d);
   endtask

   initial begin
      rst = 1'b1; rdy_in = 1'b1; rf_status = RF_NOP;
      drive(1'b0, 5'd0, 32'd0, 1'b0);
      #2;
      chk("rst_ready", in_ready, 1'b0);
      chk_idle("rst");
      chk("rst_fwd_v", fwd_valid, 1'b0);
      chk("rst_fwd_rd", fwd_rd, 5'd0);
      chk("rst_fwd_d", fwd_data, 32'd0);
      chk("rst_cnt", retire_count, 32'd0);
      step(); step();
      rst = 1'b0;
      #1;
      chk("post_rst_ready", in_ready, 1'b1);

      // single write
      drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b1);
      step();
      drive(1'b0, 5'd0, 32'd0, 1'b0);
      #1;
      chk_issue("w1_issue", RF_WRITE, 5'd5, 32'hDEADBEEF);
      chk("w1_fwd_v", fwd_valid, 1'b1);
      chk("w1_fwd_rd", fwd_rd, 5'd5);
      rf_status = RF_FINISHED;
      step();
      chk_idle("w1_confirm");
      chk("w1_cnt_hold", retire_count, 32'd0);
      step();
      rf_status = RF_NOP;
      #1;
      chk("w1_cnt", retire_count, 32'd1);
      chk("w1_fwd_off", fwd_valid, 1'b0);
      step();
      chk_idle("w1_idle");

      // x0 write is suppressed but still retires
      drive(1'b1, 5'd0, 32'h1234, 1'b1);
      step();
      drive(1'b0, 5'd0, 32'd0, 1'b0);
      #1;
      chk_issue("x0_issue", RF_NOP, 5'd0, 32'h1234);
      chk("x0_fwd_v1", fwd_valid, 1'b0);
      rf_status = RF_FINISHED;
      step();
      chk("x0_fwd_v2", fwd_valid, 1'b0);
      step();
      rf_status = RF_NOP;
      #1;
      chk("x0_cnt", retire_count, 32'd2);

      // back-pressure: third entry waits at MEM until a slot frees
      drive(1'b1, 5'd1, 32'h11, 1'b1);
      step();
      drive(1'b1, 5'd2, 32'h22, 1'b1);
      #1;
      chk("bp_ready1", in_ready, 1'b1);
      step();
      drive(1'b1, 5'd4, 32'h44, 1'b1);
      #1;
      chk("bp_full", in_ready, 1'b0);
      step(); step();
      chk("bp_still_full", in_ready, 1'b0);
      chk_idle("bp_wait");
      chk("bp_fwd_rd", fwd_rd, 5'd2);
      chk("bp_fwd_d", fwd_data, 32'h22);
      rf_status = RF_FINISHED;
      step();
      chk("bp_cnt3", retire_count, 32'd3);
      chk_issue("bp_issue_b", RF_WRITE, 5'd2, 32'h22);
      chk("bp_ready2", in_ready, 1'b1);
      step();
      drive(1'b0, 5'd0, 32'd0, 1'b0);
      #1;
      chk_idle("bp_conf_b");
      chk("bp_fwd_c", fwd_rd, 5'd4);
      step();
      chk("bp_cnt4", retire_count, 32'd4);
      chk_issue("bp_issue_c", RF_WRITE, 5'd4, 32'h44);
      step(); step();
      rf_status = RF_NOP;
      #1;
      chk("bp_cnt5", retire_count, 32'd5);
      chk_idle("bp_done");

      // forwarding picks the youngest qualifying writer
      drive(1'b1, 5'd3, 32'hA, 1'b1);
      step();
      drive(1'b1, 5'd3, 32'hB, 1'b1);
      step();
      drive(1'b0, 5'd0, 32'd0, 1'b0);
      #1;
      chk("fw_v", fwd_valid, 1'b1);
      chk("fw_rd", fwd_rd, 5'd3);
      chk("fw_d", fwd_data, 32'hB);
      rf_status = RF_FINISHED;
      step();
      chk("fw_d_after1", fwd_data, 32'hB);
      step(); step();
      rf_status = RF_NOP;
      #1;
      chk("fw_cnt", retire_count, 32'd7);
      chk("fw_off_v", fwd_valid, 1'b0);
      chk("fw_off_rd", fwd_rd, 5'd0);
      chk("fw_off_d", fwd_data, 32'd0);

      // tail without wb_en falls back to the head
      drive(1'b1, 5'd6, 32'h66, 1'b1);
      step();
      drive(1'b1, 5'd7, 32'h77, 1'b0);
      step();
      drive(1'b0, 5'd0, 32'd0, 1'b0);
      #1;
      chk("fh_rd", fwd_rd, 5'd6);
      chk("fh_d", fwd_data, 32'h66);
      rf_status = RF_FINISHED;
      step(); step(); step();
      rf_status = RF_NOP;
      #1;
      chk("fh_cnt", retire_count, 32'd9);

      // freeze during CONFIRM
      drive(1'b1, 5'd8, 32'h88, 1'b1);
      step();
      drive(1'b0, 5'd0, 32'd0, 1'b0);
      rf_status = RF_FINISHED;
      step();
      rdy_in = 1'b0;
      #1;
      chk("fz_ready", in_ready, 1'b0);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("fz_cnt", retire_count, 32'd9);
         chk("fz_we", write_back_enabled, 1'b0);
      end
      rdy_in = 1'b1;
      step();
      rf_status = RF_NOP;
      #1;
      chk("fz_cnt_after", retire_count, 32'd10);
      chk_idle("fz_idle");

      // async reset while CONFIRM holds two entries
      drive(1'b1, 5'd9, 32'h99, 1'b1);
      step();
      drive(1'b1, 5'd10, 32'hAA, 1'b1);
      step();
      drive(1'b0, 5'd0, 32'd0, 1'b0);
      #1;
      chk("ar_pre_fwd", fwd_valid, 1'b1);
      #1;
      rst = 1'b1;
      #1;
      chk("ar_ready", in_ready, 1'b0);
      chk("ar_fwd", fwd_valid, 1'b0);
      chk("ar_cnt", retire_count, 32'd0);
      chk_idle("ar");
      step();
      rst = 1'b0;
      #1;
      chk("ar_rel_ready", in_ready, 1'b1);
      step();
      chk_idle("ar_rel");
      chk("ar_rel_cnt", retire_count, 32'd0);
      chk("ar_rel_fwd", fwd_valid, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
